// File: rtl/ip_pkt_tx_buffer_pkg.sv
// Shared types and defaults for the IP packet transmit buffer.
//   tx_state_e   : buffer FSM encoding (idle, capture, send, discard)
//   DefaultDepth : default packet storage in 32-bit words
//   DefaultAw    : matching address width, clog2(DefaultDepth)
package ip_pkt_tx_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StSend    = 2'd2,
    StDiscard = 2'd3
  } tx_state_e;

  localparam int unsigned DefaultDepth = 64;
  localparam int unsigned DefaultAw    = 6;

endpackage

// File: rtl/ip_pkt_tx_buffer_if.sv
// Packet write side (from the IP encoder) and stream read side (to the MAC/PHY
// consumer) of the transmit buffer, grouped in one bundle.
//   in_data/in_wr_en/in_fin      : encoder word, write strobe, packet-complete pulse
//   out_data/out_valid/out_ready : outgoing stream word with valid/ready handshake
//   out_sop/out_eop/out_words    : first/last word flags and committed length
// Modports:
//   master : encoder + sink side (drives in_*, out_ready)
//   slave  : buffer side (drives out_* except out_ready)
interface ip_pkt_tx_buffer_if
  import ip_pkt_tx_buffer_pkg::*;
#(
  parameter int unsigned AW = DefaultAw
);
  logic [31:0] in_data;
  logic        in_wr_en;
  logic        in_fin;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [AW:0] out_words;

  modport master (
    output in_data, in_wr_en, in_fin, out_ready,
    input  out_data, out_valid, out_sop, out_eop, out_words
  );

  modport slave (
    input  in_data, in_wr_en, in_fin, out_ready,
    output out_data, out_valid, out_sop, out_eop, out_words
  );
endinterface

// File: rtl/ip_pkt_tx_buffer_word_ram.sv
// DEPTH x 32 flop-array packet store: synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, combinational from i_raddr
module ip_pkt_tx_buffer_word_ram
  import ip_pkt_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = DefaultAw
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ip_pkt_tx_buffer.sv
// Store-and-forward output stage behind the UDP/TCP-over-IP encoder. Captures one
// packet of 32-bit words, commits it on in_fin, then replays it on a valid/ready
// stream with sop/eop/length. Holds one packet at a time.
//   clk, reset     : clock, synchronous active-high reset
//   io_bus         : encoder write side and outgoing stream (slave modport)
//   o_busy         : high while sending; upstream must not start a new packet
//   o_drop         : one-cycle pulse after an overflowed packet is discarded
//   o_protocol_err : sticky, set when a write or fin arrives while sending
//   o_pkt_cnt      : packets fully transmitted, wrapping
module ip_pkt_tx_buffer
  import ip_pkt_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = DefaultAw
) (
  input  logic                clk,
  input  logic                reset,
  ip_pkt_tx_buffer_if.slave   io_bus,
  output logic                o_busy,
  output logic                o_drop,
  output logic                o_protocol_err,
  output logic [15:0]         o_pkt_cnt
);

  if (AW != $clog2(DEPTH)) begin : g_aw_check
    $error("AW must equal clog2(DEPTH)");
  end

  localparam logic [AW:0]   DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OneW   = (AW+1)'(1);
  localparam logic [AW-1:0] OneA   = AW'(1);

  tx_state_e     r_state, w_state_nxt;
  logic [AW:0]   r_wr_ptr, w_wr_ptr_nxt;  // AW+1 bits so it can hold DEPTH
  logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [AW:0]   r_len, w_len_nxt;
  logic          r_drop, w_drop_nxt;
  logic          r_protocol_err, w_protocol_err_nxt;
  logic [15:0]   r_pkt_cnt, w_pkt_cnt_nxt;

  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [31:0]   w_mem_rdata;
  logic          w_sending;
  logic          w_last;
  logic          w_hs;
  logic          w_room;

  ip_pkt_tx_buffer_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (io_bus.in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  assign w_sending = (r_state == StSend);
  assign w_last    = ({1'b0, r_rd_ptr} == (r_len - OneW));
  assign w_hs      = w_sending && io_bus.out_ready;
  assign w_room    = (r_wr_ptr < DepthW);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_len          <= '0;
      r_drop         <= 1'b0;
      r_protocol_err <= 1'b0;
      r_pkt_cnt      <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_len          <= w_len_nxt;
      r_drop         <= w_drop_nxt;
      r_protocol_err <= w_protocol_err_nxt;
      r_pkt_cnt      <= w_pkt_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_wr_ptr_nxt       = r_wr_ptr;
    w_rd_ptr_nxt       = r_rd_ptr;
    w_len_nxt          = r_len;
    w_drop_nxt         = 1'b0;
    w_protocol_err_nxt = r_protocol_err;
    w_pkt_cnt_nxt      = r_pkt_cnt;
    w_mem_we           = 1'b0;
    w_mem_waddr        = r_wr_ptr[AW-1:0];

    unique case (r_state)
      StIdle: begin
        // A bare fin here is an empty packet and is ignored.
        if (io_bus.in_wr_en) begin
          w_mem_we     = 1'b1;
          w_mem_waddr  = '0;
          w_wr_ptr_nxt = OneW;
          w_rd_ptr_nxt = '0;
          if (io_bus.in_fin) begin
            w_len_nxt   = OneW;
            w_state_nxt = StSend;
          end else begin
            w_state_nxt = StCapture;
          end
        end
      end

      StCapture: begin
        if (io_bus.in_wr_en && !w_room) begin
          // Overflow: the word is lost and the whole packet is abandoned.
          if (io_bus.in_fin) begin
            w_drop_nxt   = 1'b1;
            w_wr_ptr_nxt = '0;
            w_state_nxt  = StIdle;
          end else begin
            w_state_nxt  = StDiscard;
          end
        end else begin
          if (io_bus.in_wr_en) begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + OneW;
          end
          // A word arriving with fin is stored and counted in the length.
          if (io_bus.in_fin) begin
            w_len_nxt    = r_wr_ptr + {{AW{1'b0}}, io_bus.in_wr_en};
            w_rd_ptr_nxt = '0;
            w_state_nxt  = StSend;
          end
        end
      end

      StDiscard: begin
        if (io_bus.in_fin) begin
          w_drop_nxt   = 1'b1;
          w_wr_ptr_nxt = '0;
          w_state_nxt  = StIdle;
        end
      end

      StSend: begin
        if (io_bus.in_wr_en || io_bus.in_fin) begin
          w_protocol_err_nxt = 1'b1;
        end
        if (w_hs) begin
          if (w_last) begin
            w_pkt_cnt_nxt = r_pkt_cnt + 16'd1;
            w_wr_ptr_nxt  = '0;
            w_rd_ptr_nxt  = '0;
            w_state_nxt   = StIdle;
          end else begin
            w_rd_ptr_nxt  = r_rd_ptr + OneA;
          end
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_comb begin
    io_bus.out_valid = w_sending;
    io_bus.out_data  = w_sending ? w_mem_rdata : 32'd0;
    io_bus.out_sop   = w_sending && (r_rd_ptr == '0);
    io_bus.out_eop   = w_sending && w_last;
    io_bus.out_words = w_sending ? r_len : '0;
  end

  assign o_busy         = w_sending;
  assign o_drop         = r_drop;
  assign o_protocol_err = r_protocol_err;
  assign o_pkt_cnt      = r_pkt_cnt;

endmodule

// File: tb/tb_ip_pkt_tx_buffer.sv
// Self-checking bench for ip_pkt_tx_buffer: scoreboard of expected stream words,
// a table of packet shapes, and hand-written corner-case sequences.
module tb_ip_pkt_tx_buffer;
  import ip_pkt_tx_buffer_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [AW:0] words;
  } exp_t;

  typedef struct {
    int          n;
    logic [31:0] base;
    bit          fin_last;
    int          rdy;
    int          exp_pkt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        busy;
  logic        drop;
  logic        perr;
  logic [15:0] pkt_cnt;

  int   total;
  int   bad;
  int   hs_cnt;
  int   rdy_mode;
  logic [15:0] rdy_pat;
  logic [4:0]  rdy_idx;
  exp_t q[$];

  ip_pkt_tx_buffer_if #(.AW(AW)) bus ();

  ip_pkt_tx_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_bus         (bus),
    .o_busy         (busy),
    .o_drop         (drop),
    .o_protocol_err (perr),
    .o_pkt_cnt      (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink ready: 0 = always, 1 = random, otherwise pattern indexed per sending cycle.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      bus.out_ready = 1'b1;
      rdy_idx = '0;
    end else if (rdy_mode == 1) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      rdy_idx = '0;
    end else if (!bus.out_valid) begin
      rdy_idx = '0;
      bus.out_ready = rdy_pat[0];
    end else begin
      bus.out_ready = (rdy_idx < 5'd16) ? rdy_pat[rdy_idx[3:0]] : 1'b1;
      rdy_idx = rdy_idx + 5'd1;
    end
  end

  // Every valid cycle is compared against the scoreboard head; the head is only
  // popped on a handshake, so stalled cycles also check that the word holds.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 64'(bus.out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("out_data", 64'(bus.out_data), 64'(q[0].data));
        check("out_sop", 64'(bus.out_sop), 64'(q[0].sop));
        check("out_eop", 64'(bus.out_eop), 64'(q[0].eop));
        check("out_words", 64'(bus.out_words), 64'(q[0].words));
        check("busy_in_send", 64'(busy), 64'd1);
        if (bus.out_ready) begin
          void'(q.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  task automatic send_pkt(input int n, input logic [31:0] base, input bit fin_last,
                          input bit push);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_wr_en = 1'b1;
      bus.in_data  = base + 32'(i);
      bus.in_fin   = fin_last && (i == n - 1);
      if (push) begin
        e.data  = base + 32'(i);
        e.sop   = (i == 0);
        e.eop   = (i == n - 1);
        e.words = (AW+1)'(n);
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    bus.in_wr_en = 1'b0;
    bus.in_data  = '0;
    bus.in_fin   = !fin_last;
    if (!fin_last) begin
      @(posedge clk); #1;
      bus.in_fin = 1'b0;
    end
  endtask

  task automatic wait_drain(input int bound, input int exp_pkt);
    int k;
    k = 0;
    while (q.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    check("drain_left", 64'(q.size()), 64'd0);
    @(negedge clk);
    check("busy_after_eop", 64'(busy), 64'd0);
    check("valid_after_eop", 64'(bus.out_valid), 64'd0);
    check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
  endtask

  vec_t vecs[6];

  initial begin
    int hs0;
    vecs[0] = '{n: 2,  base: 32'h1000_0000, fin_last: 1'b1, rdy: 0, exp_pkt: 4};
    vecs[1] = '{n: 64, base: 32'h2000_0000, fin_last: 1'b1, rdy: 0, exp_pkt: 5};
    vecs[2] = '{n: 64, base: 32'h3000_0100, fin_last: 1'b0, rdy: 1, exp_pkt: 6};
    vecs[3] = '{n: 7,  base: 32'h4000_0000, fin_last: 1'b0, rdy: 1, exp_pkt: 7};
    vecs[4] = '{n: 1,  base: 32'h5000_0000, fin_last: 1'b0, rdy: 0, exp_pkt: 8};
    vecs[5] = '{n: 33, base: 32'h6000_0000, fin_last: 1'b1, rdy: 1, exp_pkt: 9};

    total = 0;
    bad = 0;
    hs_cnt = 0;
    rdy_mode = 0;
    rdy_pat = '0;
    reset = 1'b1;
    bus.in_data = '0;
    bus.in_wr_en = 1'b0;
    bus.in_fin = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_sop_eop", 64'({bus.out_sop, bus.out_eop}), 64'd0);
    check("rst_words", 64'(bus.out_words), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_perr", 64'(perr), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

    // Five words, fin on the last: first word one cycle after fin.
    send_pkt(5, 32'hA0, 1'b1, 1'b1);
    @(negedge clk);
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_first", 64'({bus.out_sop, bus.out_data}), 64'({1'b1, 32'hA0}));
    wait_drain(50, 1);

    // Three words, fin one cycle later, ready 1,0,0,1,1.
    rdy_pat = 16'h0019;
    rdy_mode = 3;
    hs0 = hs_cnt;
    send_pkt(3, 32'hB0, 1'b0, 1'b1);
    wait_drain(50, 2);
    check("stall_handshakes", 64'(hs_cnt - hs0), 64'd3);
    rdy_mode = 0;

    // Single word with write and fin together in idle.
    send_pkt(1, 32'hC0, 1'b1, 1'b1);
    @(negedge clk);
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_sop_eop", 64'({bus.out_sop, bus.out_eop}), 64'd3);
    check("single_words", 64'(bus.out_words), 64'd1);
    wait_drain(20, 3);

    for (int v = 0; v < 6; v++) begin
      rdy_mode = vecs[v].rdy;
      send_pkt(vecs[v].n, vecs[v].base, vecs[v].fin_last, 1'b1);
      wait_drain(1000, vecs[v].exp_pkt);
    end
    rdy_mode = 0;

    // Bare fin in idle is ignored.
    @(posedge clk); #1 bus.in_fin = 1'b1;
    @(posedge clk); #1 bus.in_fin = 1'b0;
    @(negedge clk);
    check("bare_fin_busy", 64'({bus.out_valid, busy}), 64'd0);
    check("bare_fin_drop", 64'(drop), 64'd0);

    // Overflow with fin after: dropped, then a 2-word packet from address 0.
    send_pkt(65, 32'hD000_0000, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_drop_pulse", 64'(drop), 64'd1);
    check("ovf_no_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("ovf_drop_clear", 64'(drop), 64'd0);
    send_pkt(2, 32'hE0, 1'b1, 1'b1);
    wait_drain(20, 10);

    // Overflow where fin coincides with the overflowing word.
    send_pkt(65, 32'hD100_0000, 1'b1, 1'b0);
    @(negedge clk);
    check("ovf2_drop_pulse", 64'(drop), 64'd1);
    check("ovf2_state", 64'({bus.out_valid, busy}), 64'd0);
    @(negedge clk);
    check("ovf2_drop_clear", 64'(drop), 64'd0);
    check("ovf2_pkt_cnt", 64'(pkt_cnt), 64'd10);

    // Write and fin during send: flagged, packet unchanged.
    rdy_pat = 16'h0038;
    rdy_mode = 3;
    send_pkt(3, 32'hF0, 1'b1, 1'b1);
    bus.in_wr_en = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    bus.in_fin   = 1'b1;
    @(posedge clk); #1;
    bus.in_wr_en = 1'b0;
    bus.in_data  = '0;
    bus.in_fin   = 1'b0;
    @(negedge clk);
    check("perr_set", 64'(perr), 64'd1);
    wait_drain(50, 11);
    check("perr_sticky", 64'(perr), 64'd1);

    // Reset during word 2 of 4.
    rdy_pat = 16'h0001;
    send_pkt(4, 32'h40, 1'b1, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("mid_rst_valid", 64'({bus.out_valid, bus.out_sop, bus.out_eop}), 64'd0);
    check("mid_rst_data_words", 64'({bus.out_data, bus.out_words}), 64'd0);
    check("mid_rst_flags", 64'({busy, drop, perr}), 64'd0);
    check("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("mid_rst_q", 64'(q.size()), 64'd0);
    send_pkt(2, 32'h77, 1'b1, 1'b1);
    wait_drain(20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ip_pkt_tx_buffer.md
Name: ip_pkt_tx_buffer

Overview:
- Store-and-forward output stage directly downstream of the combined UDP/TCP-over-IP encoder.
- Captures the 32-bit IP packet words the encoder writes (in_wr_en), commits the packet on in_fin, then replays it on a valid/ready stream with sop/eop/length for the MAC/PHY-side consumer.
- Decouples the encoder's write-only, non-stallable output from a backpressuring sink; holds one packet at a time.

Parameters:
DEPTH, 64, packet storage in 32-bit words (max packet DEPTH*4 bytes)
AW, 6, address width, must equal clog2(DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_data  in  32  packet word from IP encoder
in_wr_en  in  1  in_data valid this cycle
in_fin  in  1  one-cycle pulse: packet complete (may coincide with last in_wr_en)
out_data  out  32  current stream word
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts word when out_valid&&out_ready
out_sop  out  1  first word of packet
out_eop  out  1  last word of packet
out_words  out  AW+1  committed packet length in words, valid while out_valid
busy  out  1  high in SEND; upstream must not start a new packet
drop  out  1  one-cycle pulse: packet discarded (overflow)
protocol_err  out  1  sticky: write/fin arrived during SEND
pkt_cnt  out  16  packets fully transmitted, wraps 0xFFFF->0

Behaviour:
- Reset: clk and reset as already decided (reset reset, synchronous, active-high; clock clk). All outputs 0, state IDLE, wr_ptr=rd_ptr=len=0. Storage contents are not cleared. Reset mid-capture or mid-send abandons the packet; no drop pulse.
- States: IDLE, CAPTURE, SEND, DISCARD.
- IDLE: in_wr_en -> mem[0]=in_data, wr_ptr=1. If in_fin is in the same cycle -> len=1, go SEND; else go CAPTURE. in_fin without in_wr_en is an empty packet: ignored, stay IDLE.
- CAPTURE: in_wr_en with wr_ptr<DEPTH -> mem[wr_ptr]=in_data, wr_ptr++. in_wr_en with wr_ptr==DEPTH -> overflow: word lost; go DISCARD, or straight to IDLE with drop=1 if in_fin is the same cycle. in_fin with no overflow -> len = wr_ptr + (in_wr_en?1:0), rd_ptr=0, go SEND. A same-cycle word is stored before commit.
- DISCARD: ignore in_wr_en. On in_fin: drop=1 for one cycle, wr_ptr=0, go IDLE.
- SEND: busy=1, out_valid=1, out_data=mem[rd_ptr] (asynchronous read of flop array). Latency: in_fin at cycle T -> out_valid with first word at T+1.
  - out_sop = (rd_ptr==0); out_eop = (rd_ptr==len-1); a single-word packet has sop and eop together. out_words=len.
  - While out_ready=0, out_data/sop/eop hold stable.
  - Handshake -> rd_ptr++. Handshake with eop -> pkt_cnt++, wr_ptr=0, next cycle IDLE with out_valid=0. No back-to-back overlap: a new capture can begin in the IDLE cycle after eop.
  - in_wr_en or in_fin during SEND: ignored, protocol_err<=1 (sticky until reset).
- Outside SEND: out_valid, out_sop, out_eop and out_words are 0; out_data is don't-care and driven 0.
- Widths: len and wr_ptr are AW+1 bits so they can hold DEPTH; pkt_cnt is a 16-bit wrapping counter.

Decomposition:
- Shared package tx_buf_pkg: state encoding (IDLE=0, CAPTURE=1, SEND=2, DISCARD=3) and DEPTH default.
- One sub-module pkt_word_ram: DEPTH x 32 flop array, synchronous write, asynchronous read. Reusable by the planned decoder-side receive buffer.
- The FSM, pointers and counters stay in ip_pkt_tx_buffer.

Test Plan:
- 5 writes 0xA0..0xA4, in_fin on the last write, out_ready=1 -> T+1..T+5 out_data A0..A4; sop on A0, eop on A4, out_words=5, pkt_cnt=1, busy low the cycle after eop.
- 3 writes, in_fin one cycle after the last write; out_ready toggles 1,0,0,1,1 -> each word held while ready=0, exactly 3 handshakes, eop on the third.
- DEPTH=64: 65 writes then in_fin -> no out_valid; drop pulses 1 cycle at fin; a following 2-word packet transmits correctly with sop at mem[0].
- Single word with in_wr_en and in_fin together in IDLE -> next cycle out_valid, sop=eop=1, out_words=1.
- in_fin alone in IDLE -> no state change. Write during SEND -> protocol_err=1, and the transmitted packet is unchanged.
- Reset asserted mid-SEND at word 2 of 4 -> next cycle all outputs 0; pkt_cnt unchanged at 0; a new packet then works.
